// File: rtl/iagc_init_sequencer.sv
// -----------------------------------------------------------------------------
// iagc_init_sequencer
//   Power-up configuration sequencer for the IAGC front end. After a start
//   request it waits a settle delay. It then walks a config table, ADC words
//   first and DAC words after them. Each table word is pushed to a shared
//   serial config master as a valid/ready request. The master answers each
//   request with a one-cycle done or nack pulse. Nacked words are retried a
//   bounded number of times. A nack past the retry limit, or no answer within
//   the timeout window, aborts the sequence into ERROR. A new start request
//   restarts the sequence from index 0.
//
// Ports
//   i_clock        clock, rising edge
//   i_nReset       asynchronous active-low reset
//   i_start        start / restart request (honoured in IDLE and ERROR)
//   o_romAddr      config table index, driven during FETCH (0 otherwise)
//   i_romData      table word {addr[23:16], data[15:0]}, one cycle after addr
//   o_cfgValid     write request to config master
//   o_cfgTarget    0 = ADC, 1 = DAC
//   o_cfgAddr      register address
//   o_cfgData      register data
//   i_cfgReady     master accepts request
//   i_cfgDone      one-cycle write-complete pulse
//   i_cfgNack      one-cycle write-failed pulse
//   o_adcInitDone  all ADC words written (sticky)
//   o_dacInitDone  all DAC words written (sticky)
//   o_busy         sequence in progress
//   o_error        sequence aborted
// -----------------------------------------------------------------------------
module iagc_init_sequencer #(
    parameter int ADC_WORDS      = 4,
    parameter int DAC_WORDS      = 4,
    parameter int POWERUP_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        i_clock,
    input  logic        i_nReset,
    input  logic        i_start,
    output logic [7:0]  o_romAddr,
    input  logic [23:0] i_romData,
    output logic        o_cfgValid,
    output logic        o_cfgTarget,
    output logic [7:0]  o_cfgAddr,
    output logic [15:0] o_cfgData,
    input  logic        i_cfgReady,
    input  logic        i_cfgDone,
    input  logic        i_cfgNack,
    output logic        o_adcInitDone,
    output logic        o_dacInitDone,
    output logic        o_busy,
    output logic        o_error
);

    typedef enum logic [3:0] {
        S_IDLE, S_POWERUP, S_FETCH, S_LATCH, S_ISSUE,
        S_WAIT, S_NEXT, S_DONE, S_ERROR
    } state_e;

    localparam logic [15:0] PWR_LOAD  = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  ADC_LAST  = 8'(ADC_WORDS - 1);
    localparam logic [7:0]  SEQ_LAST  = 8'(ADC_WORDS + DAC_WORDS - 1);
    localparam logic [8:0]  ADC_CNT   = 9'(ADC_WORDS);
    localparam logic [1:0]  RETRY_MAX = 2'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic [15:0] dly_q, dly_d;
    logic [15:0] tmo_q, tmo_d;
    logic        tgt_q, tgt_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        adc_done_q, adc_done_d;
    logic        dac_done_q, dac_done_d;

    always_ff @(posedge i_clock or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            dly_q      <= '0;
            tmo_q      <= '0;
            tgt_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            adc_done_q <= 1'b0;
            dac_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            dly_q      <= dly_d;
            tmo_q      <= tmo_d;
            tgt_q      <= tgt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            adc_done_q <= adc_done_d;
            dac_done_q <= dac_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        dly_d      = dly_q;
        tmo_d      = tmo_q;
        tgt_d      = tgt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        adc_done_d = adc_done_q;
        dac_done_d = dac_done_q;

        case (state_q)
            // Start from IDLE and restart from ERROR share one path. Both
            // clear progress and flags, so a restart always replays from 0.
            S_IDLE, S_ERROR: begin
                if (i_start) begin
                    state_d    = S_POWERUP;
                    dly_d      = PWR_LOAD;
                    idx_d      = '0;
                    retry_d    = '0;
                    adc_done_d = 1'b0;
                    dac_done_d = 1'b0;
                end
            end
            S_POWERUP: begin
                if (dly_q == '0) state_d = S_FETCH;
                else             dly_d   = dly_q - 16'd1;
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                addr_d  = i_romData[23:16];
                data_d  = i_romData[15:0];
                tgt_d   = ({1'b0, idx_q} >= ADC_CNT);
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (i_cfgReady) begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A nack wins over a simultaneous done.
                if (i_cfgNack) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (i_cfgDone) begin
                    state_d = S_NEXT;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (idx_q == ADC_LAST) adc_done_d = 1'b1;
                if (idx_q == SEQ_LAST) begin
                    dac_done_d = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    assign o_romAddr     = (state_q == S_FETCH) ? idx_q : 8'd0;
    assign o_cfgValid    = (state_q == S_ISSUE);
    assign o_cfgTarget   = tgt_q;
    assign o_cfgAddr     = addr_q;
    assign o_cfgData     = data_q;
    assign o_adcInitDone = adc_done_q;
    assign o_dacInitDone = dac_done_q;
    assign o_busy        = (state_q == S_POWERUP) || (state_q == S_FETCH) ||
                           (state_q == S_LATCH)   || (state_q == S_ISSUE) ||
                           (state_q == S_WAIT)    || (state_q == S_NEXT);
    assign o_error       = (state_q == S_ERROR);

endmodule

// File: tb/tb_iagc_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_iagc_init_sequencer
//   Scoreboard bench. Directed sequences push the expected write requests into
//   exp_q. The monitor pops and compares them on every accepted request. A
//   small config-master model answers each accept from resp_q. The master
//   defaults to done when resp_q is empty.
// -----------------------------------------------------------------------------
module tb_iagc_init_sequencer;

    localparam int R_DONE = 0, R_NACK = 1, R_BOTH = 2, R_NONE = 3;

    typedef struct packed {
        logic        tgt;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        adc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start, ready, done, nack;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic        valid, tgt, adc_done, dac_done, busy, err;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;

    logic [23:0] rom [0:3];
    exp_t        exp_q[$];
    int          resp_q[$];
    int          total = 0, bad = 0;
    int          cyc = 0, n_acc = 0, acc_edge = 0;

    iagc_init_sequencer #(
        .ADC_WORDS(2), .DAC_WORDS(2), .POWERUP_CYCLES(5),
        .TIMEOUT_CYCLES(8), .MAX_RETRIES(3)
    ) dut (
        .i_clock(clk), .i_nReset(rst_n), .i_start(start),
        .o_romAddr(rom_addr), .i_romData(rom_data),
        .o_cfgValid(valid), .o_cfgTarget(tgt), .o_cfgAddr(cfg_addr),
        .o_cfgData(cfg_data), .i_cfgReady(ready), .i_cfgDone(done),
        .i_cfgNack(nack), .o_adcInitDone(adc_done), .o_dacInitDone(dac_done),
        .o_busy(busy), .o_error(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= (rom_addr < 8'd4) ? rom[rom_addr[1:0]] : 24'h0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic chk_zero(input string name);
        check(name, {valid, tgt, cfg_addr, cfg_data, rom_addr, adc_done, dac_done, busy, err}, 64'd0);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    function automatic exp_t mk(input logic [23:0] w, input logic t, input logic a);
        exp_t e;
        e.tgt = t; e.addr = w[23:16]; e.data = w[15:0]; e.adc = a;
        return e;
    endfunction

    // Monitor: a request seen valid&ready at the negedge is accepted on the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid && ready) begin
                n_acc++;
                acc_edge = cyc + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {tgt, cfg_addr, cfg_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("write_fields", {tgt, cfg_addr, cfg_data}, {e.tgt, e.addr, e.data});
                    check("adc_done_at_write", adc_done, e.adc);
                end
            end
        end
    end

    // Config master model: answers in the third WAIT cycle after each accept.
    initial begin
        int r;
        done = 1'b0; nack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && valid && ready) begin
                @(posedge clk);
                r = (resp_q.size() != 0) ? resp_q.pop_front() : R_DONE;
                if (r != R_NONE) begin
                    repeat (2) @(posedge clk);
                    #1;
                    done = (r == R_DONE) || (r == R_BOTH);
                    nack = (r == R_NACK) || (r == R_BOTH);
                    @(posedge clk); #1;
                    done = 1'b0; nack = 1'b0;
                end
            end
        end
    end

    initial begin
        int   e0, k, base;
        logic [24:0] f0;
        logic hold_ok;
        rst_n = 1'b0; start = 1'b0; ready = 1'b1;
        rom[0] = 24'h10_1234; rom[1] = 24'h11_5678;
        rom[2] = 24'h20_9ABC; rom[3] = 24'h21_DEF0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start_busy", busy, 1'b0);

        // Basic sequence: ADC 0,1 then DAC 2,3
        exp_q.push_back(mk(24'h10_1234, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h11_5678, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h20_9ABC, 1'b1, 1'b1));
        exp_q.push_back(mk(24'h21_DEF0, 1'b1, 1'b1));
        do_start();
        e0 = cyc;
        check("busy_after_start", busy, 1'b1);
        for (k = 0; k < 50 && !valid; k++) @(negedge clk);
        check("first_issue_edge", 64'(cyc - e0), 64'd7);
        for (k = 0; k < 300 && busy; k++) @(negedge clk);
        check("seq1_done_flags", {adc_done, dac_done, busy, err}, 4'b1100);
        check("seq1_writes", n_acc, 4);
        do_start();
        repeat (3) @(negedge clk);
        check("done_ignores_start", {busy, dac_done, valid}, 3'b010);

        // Reset from DONE, then ready held low, nack retries, done+nack, timeout
        @(posedge clk); #1 rst_n = 1'b0;
        #1 chk_zero("reset_from_done");
        @(negedge clk) rst_n = 1'b1;
        ready = 1'b0;
        repeat (4) resp_q.push_back(R_NACK);
        resp_q[3] = R_DONE;
        resp_q.push_back(R_BOTH); resp_q.push_back(R_DONE);
        resp_q.push_back(R_DONE); resp_q.push_back(R_NONE);
        repeat (4) exp_q.push_back(mk(24'h10_1234, 1'b0, 1'b0));
        repeat (2) exp_q.push_back(mk(24'h11_5678, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h20_9ABC, 1'b1, 1'b1));
        exp_q.push_back(mk(24'h21_DEF0, 1'b1, 1'b1));
        base = n_acc;
        do_start();
        for (k = 0; k < 50 && !valid; k++) @(negedge clk);
        f0 = {tgt, cfg_addr, cfg_data};
        check("hold_first_fields", f0, {1'b0, 24'h10_1234});
        hold_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!valid || {tgt, cfg_addr, cfg_data} != f0 || err) hold_ok = 1'b0;
        end
        check("hold_valid_stable", hold_ok, 1'b1);
        @(posedge clk); #1 ready = 1'b1;
        for (k = 0; k < 400 && !err; k++) @(negedge clk);
        check("timeout_gap", 64'(cyc - acc_edge), 64'd8);
        check("timeout_state", {err, busy, adc_done, dac_done}, 4'b1010);
        check("seq2_writes", n_acc - base, 8);

        // Restart from ERROR; four nacks on index 0 abort
        repeat (4) resp_q.push_back(R_NACK);
        repeat (4) exp_q.push_back(mk(24'h10_1234, 1'b0, 1'b0));
        base = n_acc;
        do_start();
        check("restart_clears", {err, busy, adc_done}, 3'b010);
        for (k = 0; k < 300 && !err; k++) @(negedge clk);
        check("retry_exhausted", {err, busy, adc_done, dac_done}, 4'b1000);
        check("seq3_writes", n_acc - base, 4);

        // Reset during WAIT of index 3
        exp_q.push_back(mk(24'h10_1234, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h11_5678, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h20_9ABC, 1'b1, 1'b1));
        exp_q.push_back(mk(24'h21_DEF0, 1'b1, 1'b1));
        base = n_acc;
        do_start();
        for (k = 0; k < 300 && n_acc < base + 4; k++) @(negedge clk);
        check("seq4_reached_idx3", n_acc - base, 4);
        @(posedge clk); #1;
        check("wait_idx3_busy", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_zero("reset_mid_wait");
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("no_resume_without_start", {busy, valid, err}, 3'b000);
        exp_q.push_back(mk(24'h10_1234, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h11_5678, 1'b0, 1'b0));
        exp_q.push_back(mk(24'h20_9ABC, 1'b1, 1'b1));
        exp_q.push_back(mk(24'h21_DEF0, 1'b1, 1'b1));
        base = n_acc;
        do_start();
        for (k = 0; k < 300 && busy; k++) @(negedge clk);
        check("replay_done", {adc_done, dac_done, busy, err}, 4'b1100);
        check("replay_writes", n_acc - base, 4);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
